inst_issue_queue: RTL and testbench

INST_ISSUE_QUEUE -- requirements
Module: inst_issue_queue

---
 rtl/inst_issue_queue.sv | 236 +++++++++++++++++++++++
 tb/tb_inst_issue_queue.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_issue_queue.sv
// inst_issue_queue: dual-slot in-order instruction issue queue.
//
// Two instructions can be pushed per cycle. Each one is classified and has its
// destination register decoded on the way in. The two oldest entries are
// presented every cycle, and slot 1 is offered only when it can pair safely
// with slot 0.
//
// Build option: define ISSUE_DUAL_EN to enable dual issue from slot 1.
// Without it, slot 1 never issues, its outputs read 0, and at most one entry
// pops per cycle.
//
// Ports
//   clk, rst        clock, asynchronous active-high reset
//   flush           discard every queued entry
//   in_valid[1:0]   per-slot push strobes (slot 0 is the older instruction)
//   in_inst/in_pc   two 32-bit instructions/PCs, slot k in [32k+31:32k]
//   in_ready        queue has room for two entries
//   out_valid[1:0]  per-slot issue valid
//   out_inst/out_pc head and head+1 entries, same slot packing
//   out_class       3-bit class per slot (0 ALU, 1 MULDIV, 2 MEM, 3 BRANCH,
//                   4 PRIV, 7 UNDEF)
//   out_dest        5-bit destination register per slot, 0 = none
//   out_accept      consumer takes every presented slot this cycle
//   count           current occupancy
module inst_issue_queue #(
    parameter int unsigned DEPTH = 8,               // power of two, >= 4
    parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic [1:0]       in_valid,
    input  logic [63:0]      in_inst,
    input  logic [63:0]      in_pc,
    output logic             in_ready,
    output logic [1:0]       out_valid,
    output logic [63:0]      out_inst,
    output logic [63:0]      out_pc,
    output logic [5:0]       out_class,
    output logic [9:0]       out_dest,
    input  logic             out_accept,
    output logic [CNT_W-1:0] count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    localparam logic [2:0] CLS_ALU    = 3'd0;
    localparam logic [2:0] CLS_MULDIV = 3'd1;
    localparam logic [2:0] CLS_MEM    = 3'd2;
    localparam logic [2:0] CLS_BRANCH = 3'd3;
    localparam logic [2:0] CLS_PRIV   = 3'd4;
    localparam logic [2:0] CLS_UNDEF  = 3'd7;

    // Instruction class from the opcode and (for SPECIAL) funct fields.
    function automatic logic [2:0] classify(input logic [5:0] op, input logic [5:0] fn);
        logic [2:0] cls;
        cls = CLS_UNDEF;
        if (op == 6'b000000) begin
            casez (fn)
                6'b00100?:            cls = CLS_BRANCH;   // JR, JALR
                6'b00110?:            cls = CLS_PRIV;     // SYSCALL, BREAK
                6'b0110??, 6'b0100?1: cls = CLS_MULDIV;   // MULT/DIV family, MTHI/MTLO
                6'b000000, 6'b000010, 6'b000011,
                6'b000100, 6'b000110, 6'b000111,
                6'b010000, 6'b010010,
                6'b100???, 6'b10101?: cls = CLS_ALU;      // shifts, MFHI/MFLO, ALU ops
                default:              cls = CLS_UNDEF;
            endcase
        end else begin
            casez (op)
                6'b10????:                       cls = CLS_MEM;
                6'b000001, 6'b00001?, 6'b0001??: cls = CLS_BRANCH;
                6'b010000:                       cls = CLS_PRIV;
                6'b001???:                       cls = CLS_ALU;
                default:                         cls = CLS_UNDEF;
            endcase
        end
        return cls;
    endfunction

    // Architectural destination register; 0 when the instruction writes none.
    function automatic logic [4:0] dest_of(input logic [5:0] op, input logic [4:0] rs,
                                           input logic [4:0] rt, input logic [4:0] rd);
        logic [4:0] dst;
        dst = 5'd0;
        casez (op)
            6'b000000:            dst = rd;
            6'b000011:            dst = 5'd31;
            6'b000001:            if (rt[4]) dst = 5'd31;   // REGIMM ...AL forms link
            6'b001???, 6'b100???: dst = rt;
            6'b010000:            if (rs == 5'd0) dst = rt;  // MFC0
            default:              dst = 5'd0;
        endcase
        return dst;
    endfunction

    logic [31:0] inst_mem [DEPTH];
    logic [31:0] pc_mem   [DEPTH];
    logic [2:0]  cls_mem  [DEPTH];
    logic [4:0]  dst_mem  [DEPTH];

    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] wr_ptr1;
    logic             push0;
    logic             push1;
    logic [CNT_W-1:0] n_push;
    logic [CNT_W-1:0] n_pop;
    logic [2:0]       in_cls0;
    logic [2:0]       in_cls1;
    logic [4:0]       in_dst0;
    logic [4:0]       in_dst1;
    logic             v0;
    logic             v1;
    logic [31:0]      h0_inst;
    logic [31:0]      h0_pc;
    logic [2:0]       h0_cls;
    logic [4:0]       h0_dst;

    // Push side: room for two is required even for a single push.
    assign in_ready = (count <= CNT_W'(DEPTH - 2));
    assign push0    = in_valid[0] & in_ready;
    assign push1    = push0 & in_valid[1];
    assign n_push   = CNT_W'(push0) + CNT_W'(push1);
    assign wr_ptr1  = wr_ptr + PTR_W'(1);

    assign in_cls0 = classify(in_inst[31:26], in_inst[5:0]);
    assign in_cls1 = classify(in_inst[63:58], in_inst[37:32]);
    assign in_dst0 = dest_of(in_inst[31:26], in_inst[25:21], in_inst[20:16], in_inst[15:11]);
    assign in_dst1 = dest_of(in_inst[63:58], in_inst[57:53], in_inst[52:48], in_inst[47:43]);

    // Head entry.
    assign h0_inst = inst_mem[rd_ptr];
    assign h0_pc   = pc_mem[rd_ptr];
    assign h0_cls  = cls_mem[rd_ptr];
    assign h0_dst  = dst_mem[rd_ptr];
    assign v0      = (count != '0);

`ifdef ISSUE_DUAL_EN
    logic [PTR_W-1:0] rd_ptr1;
    logic [31:0]      h1_inst;
    logic [31:0]      h1_pc;
    logic [2:0]       h1_cls;
    logic [4:0]       h1_dst;
    logic             raw;
    logic             pair_ok;

    assign rd_ptr1 = rd_ptr + PTR_W'(1);
    assign h1_inst = inst_mem[rd_ptr1];
    assign h1_pc   = pc_mem[rd_ptr1];
    assign h1_cls  = cls_mem[rd_ptr1];
    assign h1_dst  = dst_mem[rd_ptr1];

    // Slot 1 must not read what slot 0 writes.
    assign raw = (h0_dst != 5'd0) &&
                 ((h0_dst == h1_inst[25:21]) || (h0_dst == h1_inst[20:16]));

    // Pairing rules for issuing slot 1 alongside slot 0.
    always_comb begin
        pair_ok = 1'b1;
        if (count < CNT_W'(2))
            pair_ok = 1'b0;
        if ((h1_cls == CLS_BRANCH) || (h1_cls == CLS_PRIV) || (h1_cls == CLS_UNDEF))
            pair_ok = 1'b0;
        if ((h0_cls == CLS_PRIV) || (h0_cls == CLS_UNDEF))
            pair_ok = 1'b0;
        if ((h0_cls == h1_cls) && ((h0_cls == CLS_MEM) || (h0_cls == CLS_MULDIV)))
            pair_ok = 1'b0;
        if (raw)
            pair_ok = 1'b0;
    end

    assign v1 = v0 & pair_ok;
`else
    assign v1 = 1'b0;
`endif

    // Presented slots; fields of an invalid slot read as zero.
    always_comb begin
        out_valid = {v1, v0};
        out_inst  = '0;
        out_pc    = '0;
        out_class = '0;
        out_dest  = '0;
        if (v0) begin
            out_inst[31:0] = h0_inst;
            out_pc[31:0]   = h0_pc;
            out_class[2:0] = h0_cls;
            out_dest[4:0]  = h0_dst;
        end
`ifdef ISSUE_DUAL_EN
        if (v1) begin
            out_inst[63:32] = h1_inst;
            out_pc[63:32]   = h1_pc;
            out_class[5:3]  = h1_cls;
            out_dest[9:5]   = h1_dst;
        end
`endif
    end

    assign n_pop = out_accept ? (CNT_W'(v0) + CNT_W'(v1)) : '0;

    // Occupancy and pointers; flush wins over push and pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else if (flush) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            count  <= count + n_push - n_pop;
            rd_ptr <= rd_ptr + PTR_W'(n_pop);
            wr_ptr <= wr_ptr + PTR_W'(n_push);
        end
    end

    // Entry storage; contents are only observable through valid slots.
    always_ff @(posedge clk) begin
        if (push0 && !flush) begin
            inst_mem[wr_ptr] <= in_inst[31:0];
            pc_mem[wr_ptr]   <= in_pc[31:0];
            cls_mem[wr_ptr]  <= in_cls0;
            dst_mem[wr_ptr]  <= in_dst0;
        end
        if (push1 && !flush) begin
            inst_mem[wr_ptr1] <= in_inst[63:32];
            pc_mem[wr_ptr1]   <= in_pc[63:32];
            cls_mem[wr_ptr1]  <= in_cls1;
            dst_mem[wr_ptr1]  <= in_dst1;
        end
    end

endmodule

// File: tb/tb_inst_issue_queue.sv
// Self-checking bench for inst_issue_queue (scoreboard of pushed entries).
module tb_inst_issue_queue;

    localparam int DEPTH = 8;
    localparam int CNT_W = $clog2(DEPTH) + 1;

`ifdef ISSUE_DUAL_EN
    localparam bit DUAL = 1'b1;
`else
    localparam bit DUAL = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [2:0]  cls;
        logic [4:0]  dst;
    } ent_t;

    localparam logic [31:0] I_ADDU  = 32'h00221821; // addu  $3,$1,$2
    localparam logic [31:0] I_ADDIU = 32'h24040005; // addiu $4,$0,5
    localparam logic [31:0] I_SUBU  = 32'h00612823; // subu  $5,$3,$1
    localparam logic [31:0] I_ADDU6 = 32'h00243021; // addu  $6,$1,$4
    localparam logic [31:0] I_LW    = 32'h8FA80000; // lw    $8,0($29)
    localparam logic [31:0] I_SW    = 32'hAFA90004; // sw    $9,4($29)
    localparam logic [31:0] I_BEQ   = 32'h10220003;
    localparam logic [31:0] I_NOP   = 32'h00000000;
    localparam logic [31:0] I_JAL   = 32'h0C000010;
    localparam logic [31:0] I_UNDEF = 32'hFC000000;
    localparam logic [31:0] I_MULT  = 32'h00220018;
    localparam logic [31:0] I_DIVU  = 32'h0022001B;
    localparam logic [31:0] I_MFHI  = 32'h00001010; // mfhi  $2
    localparam logic [31:0] I_MFC0  = 32'h40086000; // mfc0  $8,$12
    localparam logic [31:0] I_JALR  = 32'h0040F809; // jalr  $31,$2
    localparam logic [31:0] I_SYSC  = 32'h0000000C;
    localparam logic [31:0] I_BGZAL = 32'h04310002; // bgezal $1
    localparam logic [31:0] I_BREAK = 32'h0000000D;

    localparam ent_t Z = '0;

    logic             clk;
    logic             rst;
    logic             flush;
    logic [1:0]       in_valid;
    logic [63:0]      in_inst;
    logic [63:0]      in_pc;
    logic             in_ready;
    logic [1:0]       out_valid;
    logic [63:0]      out_inst;
    logic [63:0]      out_pc;
    logic [5:0]       out_class;
    logic [9:0]       out_dest;
    logic             out_accept;
    logic [CNT_W-1:0] count;

    int   n_vec;
    int   n_err;
    int   exp_count;
    ent_t q[$];

    inst_issue_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_inst    (in_inst),
        .in_pc      (in_pc),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_inst   (out_inst),
        .out_pc     (out_pc),
        .out_class  (out_class),
        .out_dest   (out_dest),
        .out_accept (out_accept),
        .count      (count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic ent_t mk(input logic [31:0] inst, input logic [31:0] pc,
                                input logic [2:0] cls, input logic [4:0] dst);
        ent_t e;
        e.inst = inst;
        e.pc   = pc;
        e.cls  = cls;
        e.dst  = dst;
        return e;
    endfunction

    function automatic ent_t nop(input logic [31:0] pc);
        return mk(I_NOP, pc, 3'd0, 5'd0);
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        assert (act === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Check presented state against the scoreboard, then drive one cycle.
    // pair_ok states whether the current head pair may dual-issue.
    task automatic step(input logic [1:0] pv, input ent_t e0, input ent_t e1,
                        input logic acc, input logic pair_ok, input string tag);
        logic [1:0] ev;
        int         npop;
        int         npush;
        ent_t       f;
        ev = 2'b00;
        if (exp_count >= 1) ev[0] = 1'b1;
        if (DUAL && exp_count >= 2 && pair_ok) ev[1] = 1'b1;
        chk({tag, "/valid"}, 64'(out_valid), 64'(ev));
        chk({tag, "/count"}, 64'(count), 64'(exp_count));
        chk({tag, "/ready"}, 64'(in_ready), 64'(exp_count <= DEPTH - 2));
        for (int s = 0; s < 2; s++) begin
            if (ev[s]) begin
                f = q[s];
                chk($sformatf("%s/inst%0d", tag, s), 64'(out_inst[32*s +: 32]), 64'(f.inst));
                chk($sformatf("%s/pc%0d", tag, s), 64'(out_pc[32*s +: 32]), 64'(f.pc));
                chk($sformatf("%s/class%0d", tag, s), 64'(out_class[3*s +: 3]), 64'(f.cls));
                chk($sformatf("%s/dest%0d", tag, s), 64'(out_dest[5*s +: 5]), 64'(f.dst));
            end else if (s == 1) begin
                chk({tag, "/zero1"},
                    64'({out_inst[63:32], out_class[5:3], out_dest[9:5]}), 64'(0));
                chk({tag, "/zeropc1"}, 64'(out_pc[63:32]), 64'(0));
            end
        end
        npop  = acc ? (int'(ev[0]) + int'(ev[1])) : 0;
        npush = (pv[0] && exp_count <= DEPTH - 2) ? (pv[1] ? 2 : 1) : 0;
        in_valid   = pv;
        in_inst    = {e1.inst, e0.inst};
        in_pc      = {e1.pc, e0.pc};
        out_accept = acc;
        tick();
        in_valid   = 2'b00;
        in_inst    = '0;
        in_pc      = '0;
        out_accept = 1'b0;
        repeat (npop) void'(q.pop_front());
        if (npush >= 1) q.push_back(e0);
        if (npush == 2) q.push_back(e1);
        exp_count = exp_count + npush - npop;
    endtask

    task automatic drain(input logic pair_ok, input string tag);
        for (int g = 0; g < 4 * DEPTH && exp_count > 0; g++)
            step(2'b00, Z, Z, 1'b1, pair_ok, tag);
    endtask

    initial begin
        n_vec      = 0;
        n_err      = 0;
        exp_count  = 0;
        rst        = 1'b1;
        flush      = 1'b0;
        in_valid   = 2'b00;
        in_inst    = '0;
        in_pc      = '0;
        out_accept = 1'b0;
        tick();
        tick();
        chk("rst/count", 64'(count), 64'(0));
        chk("rst/valid", 64'(out_valid), 64'(0));
        chk("rst/ready", 64'(in_ready), 64'(1));
        rst = 1'b0;

        // ADDU + ADDIU pair, accept held high while empty
        step(2'b11, mk(I_ADDU, 32'h100, 3'd0, 5'd3), mk(I_ADDIU, 32'h104, 3'd0, 5'd4),
             1'b1, 1'b0, "t1_push");
        step(2'b00, Z, Z, 1'b1, 1'b1, "t1_issue");
        drain(1'b0, "t1_drain");

        // RAW through rs, then through rt
        step(2'b11, mk(I_ADDU, 32'h200, 3'd0, 5'd3), mk(I_SUBU, 32'h204, 3'd0, 5'd5),
             1'b0, 1'b0, "t2_push");
        step(2'b00, Z, Z, 1'b1, 1'b0, "t2_raw");
        step(2'b00, Z, Z, 1'b1, 1'b0, "t2_subu");
        drain(1'b0, "t2_drain");
        step(2'b11, mk(I_ADDIU, 32'h210, 3'd0, 5'd4), mk(I_ADDU6, 32'h214, 3'd0, 5'd6),
             1'b0, 1'b0, "t2b_push");
        step(2'b00, Z, Z, 1'b1, 1'b0, "t2b_raw");
        drain(1'b0, "t2b_drain");

        // MEM pair, BRANCH+NOP, NOP+JAL
        step(2'b11, mk(I_LW, 32'h300, 3'd2, 5'd8), mk(I_SW, 32'h304, 3'd2, 5'd0),
             1'b0, 1'b0, "t3_mem_push");
        step(2'b00, Z, Z, 1'b1, 1'b0, "t3_mem");
        drain(1'b0, "t3_mem_drain");
        step(2'b11, mk(I_BEQ, 32'h310, 3'd3, 5'd0), nop(32'h314), 1'b0, 1'b0, "t3_br_push");
        step(2'b00, Z, Z, 1'b1, 1'b1, "t3_br");
        drain(1'b0, "t3_br_drain");
        step(2'b11, nop(32'h320), mk(I_JAL, 32'h324, 3'd3, 5'd31), 1'b0, 1'b0, "t3_jal_push");
        step(2'b00, Z, Z, 1'b1, 1'b0, "t3_jal");
        drain(1'b0, "t3_jal_drain");

        // MULDIV pair blocked, MULDIV+ALU allowed
        step(2'b11, mk(I_MULT, 32'h400, 3'd1, 5'd0), mk(I_DIVU, 32'h404, 3'd1, 5'd0),
             1'b0, 1'b0, "t4_push");
        step(2'b01, mk(I_MFHI, 32'h408, 3'd0, 5'd2), Z, 1'b0, 1'b0, "t4_push2");
        step(2'b00, Z, Z, 1'b1, 1'b0, "t4_md");
        step(2'b00, Z, Z, 1'b1, 1'b1, "t4_mdalu");
        drain(1'b0, "t4_drain");

        // Undefined opcode in slot 0
        step(2'b11, mk(I_UNDEF, 32'h500, 3'd7, 5'd0), nop(32'h504), 1'b0, 1'b0, "t5_push");
        step(2'b00, Z, Z, 1'b1, 1'b0, "t5_undef");
        drain(1'b0, "t5_drain");

        // in_valid=2'b10 pushes nothing
        step(2'b10, nop(32'h580), nop(32'h584), 1'b0, 1'b0, "t5b_v10");
        step(2'b00, Z, Z, 1'b0, 1'b0, "t5b_empty");

        // Single pushes up to DEPTH-1, then a rejected push
        step(2'b01, mk(I_MFC0,  32'h600, 3'd4, 5'd8),  Z, 1'b0, 1'b0, "t6_f1");
        step(2'b01, mk(I_JALR,  32'h604, 3'd3, 5'd31), Z, 1'b0, 1'b0, "t6_f2");
        step(2'b01, mk(I_SYSC,  32'h608, 3'd4, 5'd0),  Z, 1'b0, 1'b0, "t6_f3");
        step(2'b01, mk(I_BGZAL, 32'h60C, 3'd3, 5'd31), Z, 1'b0, 1'b0, "t6_f4");
        step(2'b01, mk(I_UNDEF, 32'h610, 3'd7, 5'd0),  Z, 1'b0, 1'b0, "t6_f5");
        step(2'b01, mk(I_JAL,   32'h614, 3'd3, 5'd31), Z, 1'b0, 1'b0, "t6_f6");
        step(2'b01, mk(I_BREAK, 32'h618, 3'd4, 5'd0),  Z, 1'b0, 1'b0, "t6_f7");
        step(2'b11, mk(I_ADDU, 32'h61C, 3'd0, 5'd3), nop(32'h620), 1'b0, 1'b0, "t6_full");
        step(2'b00, Z, Z, 1'b0, 1'b0, "t6_hold");
        drain(1'b0, "t6_drain");

        // Pair pushes up to DEPTH
        for (int k = 0; k < DEPTH / 2; k++)
            step(2'b11, nop(32'h700 + 32'(8 * k)), nop(32'h704 + 32'(8 * k)),
                 1'b0, 1'b1, "t7_fill");
        step(2'b11, nop(32'h7F0), nop(32'h7F4), 1'b0, 1'b1, "t7_full");
        drain(1'b1, "t7_drain");

        // Streaming push and pop across several pointer wraps
        for (int k = 0; k < 3 * DEPTH / 2; k++)
            step(2'b11, nop(32'h1000 + 32'(8 * k)), nop(32'h1004 + 32'(8 * k)),
                 1'b1, 1'b1, "t8_wrap");
        drain(1'b1, "t8_drain");

        // Flush at count 5 with a simultaneous push and accept
        step(2'b11, nop(32'h2000), nop(32'h2004), 1'b0, 1'b1, "t9_fill");
        step(2'b11, nop(32'h2008), nop(32'h200C), 1'b0, 1'b1, "t9_fill");
        step(2'b01, nop(32'h2010), Z, 1'b0, 1'b1, "t9_fill");
        chk("t9_pre/count", 64'(count), 64'(5));
        flush      = 1'b1;
        in_valid   = 2'b11;
        in_inst    = {I_ADDU, I_ADDU};
        in_pc      = {32'h2018, 32'h2014};
        out_accept = 1'b1;
        tick();
        flush      = 1'b0;
        in_valid   = 2'b00;
        in_inst    = '0;
        in_pc      = '0;
        out_accept = 1'b0;
        q.delete();
        exp_count = 0;
        step(2'b00, Z, Z, 1'b0, 1'b0, "t9_post");
        step(2'b11, mk(I_ADDU, 32'h2100, 3'd0, 5'd3), mk(I_ADDIU, 32'h2104, 3'd0, 5'd4),
             1'b0, 1'b0, "t9_repush");
        step(2'b00, Z, Z, 1'b1, 1'b1, "t9_reissue");
        drain(1'b0, "t9_drain");

        // Asynchronous reset while entries are queued
        step(2'b11, nop(32'h3000), nop(32'h3004), 1'b0, 1'b1, "t10_fill");
        step(2'b01, nop(32'h3008), Z, 1'b0, 1'b1, "t10_fill");
        rst = 1'b1;
        #1;
        chk("t10_async/count", 64'(count), 64'(0));
        chk("t10_async/valid", 64'(out_valid), 64'(0));
        chk("t10_async/ready", 64'(in_ready), 64'(1));
        tick();
        rst = 1'b0;
        q.delete();
        exp_count = 0;
        step(2'b01, mk(I_LW, 32'h3100, 3'd2, 5'd8), Z, 1'b0, 1'b0, "t10_push");
        step(2'b00, Z, Z, 1'b1, 1'b0, "t10_issue");
        step(2'b00, Z, Z, 1'b0, 1'b0, "t10_empty");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
